// File: rtl/mod_cache_arbiter_if.sv
// Bundle of the I-cache, D-cache and memory-bus handshakes around the cache arbiter.
// The master modport is the arbiter's view; slave is the caches/memory side.
interface mod_cache_arbiter_if #(
    parameter int ADDRWIDTH = 64,
    parameter int TAGWIDTH  = 13,
    parameter int BEATWIDTH = 64,
    parameter int BEATS     = 8
);
    localparam int LINEWIDTH = BEATS * BEATWIDTH;

    logic                 i_reqcyc;
    logic [ADDRWIDTH-1:0] i_req;
    logic [TAGWIDTH-1:0]  i_reqtag;
    logic                 i_reqack;
    logic                 i_respcyc;
    logic [LINEWIDTH-1:0] i_resp;
    logic [TAGWIDTH-1:0]  i_resptag;
    logic                 i_respack;

    logic                 d_reqcyc;
    logic [ADDRWIDTH-1:0] d_req;
    logic [TAGWIDTH-1:0]  d_reqtag;
    logic [LINEWIDTH-1:0] d_wdata;
    logic                 d_reqack;
    logic                 d_respcyc;
    logic [LINEWIDTH-1:0] d_resp;
    logic [TAGWIDTH-1:0]  d_resptag;
    logic                 d_respack;

    logic                 m_reqcyc;
    logic [BEATWIDTH-1:0] m_req;
    logic [TAGWIDTH-1:0]  m_reqtag;
    logic                 m_reqack;
    logic                 m_respcyc;
    logic [BEATWIDTH-1:0] m_resp;
    logic [TAGWIDTH-1:0]  m_resptag;
    logic                 m_respack;

    modport master (
        input  i_reqcyc, i_req, i_reqtag, i_respack,
        output i_reqack, i_respcyc, i_resp, i_resptag,
        input  d_reqcyc, d_req, d_reqtag, d_wdata, d_respack,
        output d_reqack, d_respcyc, d_resp, d_resptag,
        output m_reqcyc, m_req, m_reqtag, m_respack,
        input  m_reqack, m_respcyc, m_resp, m_resptag
    );

    modport slave (
        output i_reqcyc, i_req, i_reqtag, i_respack,
        input  i_reqack, i_respcyc, i_resp, i_resptag,
        output d_reqcyc, d_req, d_reqtag, d_wdata, d_respack,
        input  d_reqack, d_respcyc, d_resp, d_resptag,
        input  m_reqcyc, m_req, m_reqtag, m_respack,
        output m_reqack, m_respcyc, m_resp, m_resptag
    );
endinterface

// File: rtl/mod_cache_arbiter.sv
// Round-robin I/D cache arbiter: one line transaction at a time, serialised onto
// the memory bus as an address phase plus BEATS data beats.
module mod_cache_arbiter #(
    parameter int ADDRWIDTH = 64,
    parameter int TAGWIDTH  = 13,
    parameter int BEATWIDTH = 64,
    parameter int BEATS     = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    mod_cache_arbiter_if.master  bus
);
    localparam int LINEWIDTH = BEATS * BEATWIDTH;
    localparam int CNTW      = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNTW-1:0] LAST_BEAT = CNTW'(BEATS - 1);

    typedef enum logic [2:0] {IDLE, ISSUE, RD_BEATS, WR_BEATS, DELIVER} state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [CNTW-1:0]      r_cnt;
    logic                 r_last_d;
    logic                 r_port_d;
    logic                 r_is_wr;
    logic [ADDRWIDTH-1:0] r_addr;
    logic [TAGWIDTH-1:0]  r_tag;
    logic [LINEWIDTH-1:0] r_line;
    logic                 r_reqack_i;
    logic                 r_reqack_d;

    logic                 w_any_req;
    logic                 w_grant_d;
    logic                 w_beat_ok;
    logic [BEATWIDTH-1:0] w_beat [BEATS];

    genvar gi;
    generate
        for (gi = 0; gi < BEATS; gi++) begin : g_beat
            assign w_beat[gi] = r_line[gi*BEATWIDTH +: BEATWIDTH];
        end
    endgenerate

    assign w_any_req = bus.i_reqcyc | bus.d_reqcyc;
    // Sole requester wins; on a tie the port that was not granted last wins.
    assign w_grant_d = bus.d_reqcyc & (~bus.i_reqcyc | ~r_last_d);
    assign w_beat_ok = bus.m_respcyc && (bus.m_resptag == r_tag);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        bus.i_reqack  = r_reqack_i;
        bus.d_reqack  = r_reqack_d;
        bus.i_respcyc = 1'b0;
        bus.i_resp    = '0;
        bus.i_resptag = '0;
        bus.d_respcyc = 1'b0;
        bus.d_resp    = '0;
        bus.d_resptag = '0;
        bus.m_reqcyc  = 1'b0;
        bus.m_req     = '0;
        bus.m_reqtag  = '0;
        bus.m_respack = bus.m_respcyc;
        case (r_state)
            IDLE: begin
                if (w_any_req) w_state_next = ISSUE;
            end
            ISSUE: begin
                bus.m_reqcyc = 1'b1;
                bus.m_req    = BEATWIDTH'(r_addr);
                bus.m_reqtag = r_tag;
                if (bus.m_reqack) w_state_next = r_is_wr ? WR_BEATS : RD_BEATS;
            end
            RD_BEATS: begin
                if (w_beat_ok && r_cnt == LAST_BEAT) w_state_next = DELIVER;
            end
            WR_BEATS: begin
                bus.m_reqcyc = 1'b1;
                bus.m_req    = w_beat[r_cnt];
                bus.m_reqtag = r_tag;
                if (bus.m_reqack && r_cnt == LAST_BEAT) w_state_next = DELIVER;
            end
            DELIVER: begin
                if (r_port_d) begin
                    bus.d_respcyc = 1'b1;
                    bus.d_resptag = r_tag;
                    bus.d_resp    = r_is_wr ? '0 : r_line;
                    if (bus.d_respack) w_state_next = IDLE;
                end else begin
                    bus.i_respcyc = 1'b1;
                    bus.i_resptag = r_tag;
                    bus.i_resp    = r_line;
                    if (bus.i_respack) w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt      <= '0;
            r_last_d   <= 1'b1;
            r_port_d   <= 1'b0;
            r_is_wr    <= 1'b0;
            r_addr     <= '0;
            r_tag      <= '0;
            r_line     <= '0;
            r_reqack_i <= 1'b0;
            r_reqack_d <= 1'b0;
        end else begin
            r_reqack_i <= 1'b0;
            r_reqack_d <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_port_d   <= w_grant_d;
                        r_last_d   <= w_grant_d;
                        r_reqack_i <= ~w_grant_d;
                        r_reqack_d <= w_grant_d;
                        r_addr     <= w_grant_d ? bus.d_req : bus.i_req;
                        r_tag      <= w_grant_d ? bus.d_reqtag : bus.i_reqtag;
                        r_is_wr    <= w_grant_d & bus.d_reqtag[TAGWIDTH-1];
                        r_line     <= w_grant_d ? bus.d_wdata : '0;
                    end
                end
                ISSUE: begin
                    if (bus.m_reqack) r_cnt <= '0;
                end
                RD_BEATS: begin
                    // Foreign-tagged beats are acked combinationally but never stored.
                    if (w_beat_ok) begin
                        r_line[int'(r_cnt)*BEATWIDTH +: BEATWIDTH] <= bus.m_resp;
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                WR_BEATS: begin
                    if (bus.m_reqack) r_cnt <= r_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mod_cache_arbiter.sv
// Randomised bench for mod_cache_arbiter: a transaction-level model predicts grant
// order, memory-bus traffic and delivered lines.
module tb_mod_cache_arbiter;
    localparam int AW = 64;
    localparam int TW = 13;
    localparam int BW = 64;
    localparam int NB = 8;
    localparam int LW = NB * BW;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mod_cache_arbiter_if #(.ADDRWIDTH(AW), .TAGWIDTH(TW), .BEATWIDTH(BW), .BEATS(NB)) bus ();

    mod_cache_arbiter #(.ADDRWIDTH(AW), .TAGWIDTH(TW), .BEATWIDTH(BW), .BEATS(NB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    bit          model_last_d;
    logic [63:0] g_beats [NB];

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic rand_beats();
        for (int k = 0; k < NB; k++) g_beats[k] = {$urandom, $urandom};
    endtask

    // One complete line transaction. The loser of a tie keeps its reqcyc high on exit.
    task automatic run_txn(input bit req_i, input bit req_d,
                           input logic [AW-1:0] a_i, input logic [AW-1:0] a_d,
                           input logic [TW-1:0] t_i, input logic [TW-1:0] t_d,
                           input logic [LW-1:0] wd, input int st_lo, input int st_hi,
                           input int junk_pct, input int hold, input logic [TW-1:0] jmask);
        bit            win_d;
        bit            wr;
        logic [AW-1:0] a;
        logic [TW-1:0] t;
        logic [LW-1:0] exp_line;
        int            s;
        win_d = req_d && (!req_i || !model_last_d);
        wr    = win_d && t_d[TW-1];
        a     = win_d ? a_d : a_i;
        t     = win_d ? t_d : t_i;
        for (int k = 0; k < NB; k++) exp_line[k*BW +: BW] = wr ? 64'h0 : g_beats[k];

        bus.i_reqcyc = req_i; bus.i_req = a_i; bus.i_reqtag = t_i;
        bus.d_reqcyc = req_d; bus.d_req = a_d; bus.d_reqtag = t_d; bus.d_wdata = wd;
        tick();
        bus.m_respcyc = 1'b0;
        model_last_d = win_d;
        n_checks++;
        if ({bus.i_reqack, bus.d_reqack} !== {~win_d, win_d})
            $display("FAIL reqack: got i=%b d=%b want i=%b d=%b",
                     bus.i_reqack, bus.d_reqack, ~win_d, win_d);
        else n_pass++;
        if (win_d) bus.d_reqcyc = 1'b0; else bus.i_reqcyc = 1'b0;

        s = int'($urandom_range(st_hi, st_lo));
        for (int k = 0; k <= s; k++) begin
            n_checks++;
            if ({bus.m_reqcyc, bus.m_req, bus.m_reqtag} !== {1'b1, a, t})
                $display("FAIL addr_phase: got cyc=%b req=%h tag=%h want cyc=1 req=%h tag=%h",
                         bus.m_reqcyc, bus.m_req, bus.m_reqtag, a, t);
            else n_pass++;
            bus.m_reqack = (k == s);
            tick();
            bus.m_reqack = 1'b0;
        end
        n_checks++;
        if ({bus.i_reqack, bus.d_reqack} !== 2'b00)
            $display("FAIL reqack_pulse: got i=%b d=%b want 0 0", bus.i_reqack, bus.d_reqack);
        else n_pass++;

        for (int k = 0; k < NB; k++) begin
            s = int'($urandom_range(st_hi, st_lo));
            if (wr) begin
                for (int j = 0; j <= s; j++) begin
                    n_checks++;
                    if ({bus.m_reqcyc, bus.m_req, bus.m_reqtag} !== {1'b1, wd[k*BW +: BW], t})
                        $display("FAIL wr_beat%0d: got cyc=%b req=%h tag=%h want cyc=1 req=%h tag=%h",
                                 k, bus.m_reqcyc, bus.m_req, bus.m_reqtag, wd[k*BW +: BW], t);
                    else n_pass++;
                    bus.m_reqack = (j == s);
                    tick();
                    bus.m_reqack = 1'b0;
                end
            end else begin
                for (int j = 0; j < s; j++) tick();
                if (int'($urandom_range(99, 0)) < junk_pct) begin
                    bus.m_respcyc = 1'b1; bus.m_resptag = t ^ jmask; bus.m_resp = {$urandom, $urandom};
                    n_checks++;
                    if (bus.m_respack !== 1'b1)
                        $display("FAIL junk_ack: got %b want 1", bus.m_respack);
                    else n_pass++;
                    tick();
                end
                bus.m_respcyc = 1'b1; bus.m_resptag = t; bus.m_resp = g_beats[k];
                n_checks++;
                if (bus.m_respack !== 1'b1)
                    $display("FAIL beat_ack: got %b want 1", bus.m_respack);
                else n_pass++;
                tick();
                bus.m_respcyc = 1'b0;
            end
            if (k < NB - 1) begin
                n_checks++;
                if ({bus.i_respcyc, bus.d_respcyc} !== 2'b00)
                    $display("FAIL early_resp: got i=%b d=%b after beat %0d want 0 0",
                             bus.i_respcyc, bus.d_respcyc, k);
                else n_pass++;
            end
        end

        for (int h = 0; h <= hold; h++) begin
            n_checks++;
            if ({bus.i_respcyc, bus.d_respcyc, bus.i_reqack, bus.d_reqack, bus.m_reqcyc}
                    !== {~win_d, win_d, 3'b000})
                $display("FAIL deliver_ctl: got respcyc i=%b d=%b reqack i=%b d=%b mcyc=%b want respcyc i=%b d=%b",
                         bus.i_respcyc, bus.d_respcyc, bus.i_reqack, bus.d_reqack, bus.m_reqcyc,
                         ~win_d, win_d);
            else n_pass++;
            n_checks++;
            if ((win_d ? {bus.d_resptag, bus.d_resp} : {bus.i_resptag, bus.i_resp}) !== {t, exp_line})
                $display("FAIL deliver_data: got tag=%h line=%h want tag=%h line=%h",
                         win_d ? bus.d_resptag : bus.i_resptag, win_d ? bus.d_resp : bus.i_resp,
                         t, exp_line);
            else n_pass++;
            if (win_d) bus.d_respack = (h == hold); else bus.i_respack = (h == hold);
            tick();
            bus.i_respack = 1'b0; bus.d_respack = 1'b0;
        end
        n_checks++;
        if ({bus.i_respcyc, bus.d_respcyc, bus.i_reqack, bus.d_reqack, bus.m_reqcyc} !== 5'b0)
            $display("FAIL idle_return: got respcyc i=%b d=%b reqack i=%b d=%b mcyc=%b want all 0",
                     bus.i_respcyc, bus.d_respcyc, bus.i_reqack, bus.d_reqack, bus.m_reqcyc);
        else n_pass++;
        $display("txn %s %s addr=%h tag=%h", win_d ? "D" : "I", wr ? "write" : "read", a, t);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.i_reqcyc = 1'b1; bus.i_req = 64'h55; bus.i_reqtag = 13'h1;
        bus.d_reqcyc = 1'b1; bus.d_req = 64'h66; bus.d_reqtag = 13'h1002; bus.d_wdata = '1;
        bus.i_respack = 1'b0; bus.d_respack = 1'b0;
        bus.m_reqack = 1'b1; bus.m_respcyc = 1'b1; bus.m_resp = 64'hdead; bus.m_resptag = 13'h1;
        tick(); tick();
        n_checks++;
        if ({bus.i_reqack, bus.d_reqack, bus.i_respcyc, bus.d_respcyc, bus.m_reqcyc} !== 5'b0)
            $display("FAIL reset_ctl: got %b want 00000",
                     {bus.i_reqack, bus.d_reqack, bus.i_respcyc, bus.d_respcyc, bus.m_reqcyc});
        else n_pass++;
        n_checks++;
        if ({bus.m_req, bus.m_reqtag, bus.i_resptag, bus.d_resptag} !== '0 ||
            bus.i_resp !== '0 || bus.d_resp !== '0)
            $display("FAIL reset_data: got m_req=%h m_reqtag=%h want 0", bus.m_req, bus.m_reqtag);
        else n_pass++;
        n_checks++;
        if (bus.m_respack !== 1'b1)
            $display("FAIL reset_respack: got %b want 1", bus.m_respack);
        else n_pass++;
        bus.i_reqcyc = 1'b0; bus.d_reqcyc = 1'b0; bus.m_reqack = 1'b0; bus.m_respcyc = 1'b0;
        reset = 1'b0;
        model_last_d = 1'b1;
        tick();
        $display("test_reset done");
    endtask

    task automatic test_i_read();
        for (int k = 0; k < NB; k++) g_beats[k] = 64'(k);
        run_txn(1, 0, 64'h1000, 64'h0, 13'h005, 13'h0, '0, 0, 0, 0, 0, 13'h0);
    endtask

    task automatic test_arbitration();
        for (int n = 0; n < 4; n++) begin
            rand_beats();
            run_txn(1, 1, 64'h2000 + 64'(n), 64'h3000 + 64'(n), 13'h010 + 13'(n), 13'h020 + 13'(n),
                    '0, 0, 1, 0, 0, 13'h0);
        end
        rand_beats();
        run_txn(1, 0, 64'h2100, 64'h0, 13'h030, 13'h0, '0, 0, 1, 0, 0, 13'h0);
    endtask

    task automatic test_d_write();
        logic [LW-1:0] wd;
        for (int k = 0; k < NB; k++) wd[k*BW +: BW] = 64'hA0 + 64'(k);
        run_txn(0, 1, 64'h0, 64'h4000, 13'h0, 13'h1003, wd, 2, 2, 0, 1, 13'h0);
    endtask

    task automatic test_tag_filter();
        rand_beats();
        run_txn(1, 0, 64'h5000, 64'h0, 13'h005, 13'h0, '0, 0, 1, 100, 0, 13'h0FA);
    endtask

    task automatic test_reset_abort();
        rand_beats();
        bus.i_reqcyc = 1'b1; bus.i_req = 64'h6000; bus.i_reqtag = 13'h011;
        tick();
        bus.i_reqcyc = 1'b0;
        bus.m_reqack = 1'b1;
        tick();
        bus.m_reqack = 1'b0;
        for (int k = 0; k < 4; k++) begin
            bus.m_respcyc = 1'b1; bus.m_resptag = 13'h011; bus.m_resp = g_beats[k];
            tick();
        end
        bus.m_respcyc = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_last_d = 1'b1;
        n_checks++;
        if ({bus.m_reqcyc, bus.m_req, bus.m_reqtag, bus.i_respcyc, bus.i_resptag, bus.i_reqack} !== '0 ||
            bus.i_resp !== '0)
            $display("FAIL abort_outputs: got mcyc=%b m_req=%h icyc=%b want 0",
                     bus.m_reqcyc, bus.m_req, bus.i_respcyc);
        else n_pass++;
        for (int k = 4; k < NB - 1; k++) begin
            bus.m_respcyc = 1'b1; bus.m_resptag = 13'h011; bus.m_resp = g_beats[k];
            n_checks++;
            if ({bus.m_respack, bus.m_reqcyc, bus.i_respcyc} !== 3'b100)
                $display("FAIL stale_beat%0d: got ack=%b mcyc=%b icyc=%b want 1 0 0",
                         k, bus.m_respack, bus.m_reqcyc, bus.i_respcyc);
            else n_pass++;
            tick();
        end
        bus.m_respcyc = 1'b1; bus.m_resptag = 13'h011; bus.m_resp = g_beats[NB-1];
        n_checks++;
        if (bus.m_respack !== 1'b1)
            $display("FAIL stale_with_req: got ack=%b want 1", bus.m_respack);
        else n_pass++;
        rand_beats();
        run_txn(1, 0, 64'h7000, 64'h0, 13'h011, 13'h0, '0, 0, 1, 0, 0, 13'h0);
    endtask

    task automatic test_deliver_stall();
        rand_beats();
        run_txn(0, 1, 64'h0, 64'h8000, 13'h0, 13'h040, '0, 0, 0, 0, 0, 13'h0);
        rand_beats();
        run_txn(1, 1, 64'h9000, 64'hA000, 13'h041, 13'h042, '0, 0, 0, 0, 5, 13'h0);
        rand_beats();
        run_txn(0, 1, 64'h0, 64'hA000, 13'h0, 13'h042, '0, 0, 0, 0, 0, 13'h0);
    endtask

    task automatic test_random();
        bit            pend_i = 1'b0;
        bit            pend_d = 1'b0;
        bit            ri;
        bit            rd;
        logic [LW-1:0] wd;
        for (int n = 0; n < 24; n++) begin
            ri = pend_i | 1'($urandom_range(1, 0));
            rd = pend_d | 1'($urandom_range(1, 0));
            if (!ri && !rd) ri = 1'b1;
            for (int k = 0; k < NB; k++) wd[k*BW +: BW] = {$urandom, $urandom};
            rand_beats();
            run_txn(ri, rd, {$urandom, $urandom}, {$urandom, $urandom},
                    13'($urandom), 13'($urandom), wd, 0, 3, 30,
                    int'($urandom_range(3, 0)), 13'($urandom_range(8191, 1)));
            pend_d = ri && rd && !model_last_d;
            pend_i = ri && rd && model_last_d;
        end
        rand_beats();
        if (pend_i) run_txn(1, 0, 64'hB000, 64'h0, 13'h050, 13'h0, '0, 0, 2, 30, 1, 13'h1);
        if (pend_d) run_txn(0, 1, 64'h0, 64'hC000, 13'h0, 13'h051, '0, 0, 2, 30, 1, 13'h1);
    endtask

    initial begin
        test_reset();
        test_i_read();
        test_arbitration();
        test_d_write();
        test_tag_filter();
        test_reset_abort();
        test_deliver_stall();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
